// File: rtl/bomb_defuse_ctrl.sv
// Bomb game controller: input conditioning plus arm/defuse/explode FSM feeding the dot-matrix display.
// Optional feature: define BOMB_STRIKE_EN to forgive one wrong cut per game.
module bomb_defuse_ctrl #(
    parameter int unsigned DB_CYCLES = 16,
    parameter logic [7:0]  CODE      = 8'b10_00_11_01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_sw,
    input  logic       arm_btn,
    input  logic [3:0] wire_cut,
    input  logic       fail,
    output logic       start,
    output logic       bomb_switch,
    output logic       defused,
    output logic       exploded,
    output logic [2:0] progress,
    output logic [1:0] state
);

    localparam int unsigned CW = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        DEFUSED  = 2'd2,
        EXPLODED = 2'd3
    } state_t;

    state_t st;

    // Bit order: [0] power, [1] arm, [5:2] wires, [6] fail (sync only)
    logic [6:0]    sync1, sync2;
    logic [5:0]    db;
    logic [CW-1:0] cnt [6];
    logic          arm_q, fail_q;
    logic [3:0]    wire_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {fail, wire_cut, arm_btn, power_sw};
            sync2 <= sync1;
        end
    end

    // Counter only runs while the sample disagrees with the accepted value, so it never passes DB_CYCLES-1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db <= '0;
            for (int unsigned i = 0; i < 6; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 6; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DB_CYCLES - 1)) begin
                    db[i]  <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arm_q  <= 1'b0;
            wire_q <= '0;
            fail_q <= 1'b0;
        end else begin
            arm_q  <= db[1];
            wire_q <= db[5:2];
            fail_q <= sync2[6];
        end
    end

    logic       pw_db, arm_edge, fail_edge, correct_cut, wrong_cut;
    logic [3:0] wire_db, wire_edge;
    logic [1:0] exp_idx;

    always_comb begin
        pw_db       = db[0];
        wire_db     = db[5:2];
        arm_edge    = db[1] & ~arm_q;
        wire_edge   = wire_db & ~wire_q;
        fail_edge   = sync2[6] & ~fail_q;
        exp_idx     = CODE[{progress[1:0], 1'b0} +: 2];
        correct_cut = (wire_edge == (4'b0001 << exp_idx));
        wrong_cut   = (wire_edge != 4'b0000) && !correct_cut;
    end

`ifdef BOMB_STRIKE_EN
    logic strike;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st          <= IDLE;
            progress    <= '0;
            start       <= 1'b0;
            bomb_switch <= 1'b0;
            defused     <= 1'b0;
            exploded    <= 1'b0;
`ifdef BOMB_STRIKE_EN
            strike      <= 1'b0;
`endif
        end else begin
            bomb_switch <= pw_db;
            if (!pw_db) begin
                st       <= IDLE;
                progress <= '0;
                start    <= 1'b0;
                defused  <= 1'b0;
                exploded <= 1'b0;
            end else begin
                case (st)
                    ARMED: begin
                        if (fail_edge) begin
                            st       <= EXPLODED;
                            start    <= 1'b0;
                            exploded <= 1'b1;
                        end else if (wrong_cut) begin
`ifdef BOMB_STRIKE_EN
                            if (strike) begin
                                st       <= EXPLODED;
                                start    <= 1'b0;
                                exploded <= 1'b1;
                            end else begin
                                strike <= 1'b1;
                            end
`else
                            st       <= EXPLODED;
                            start    <= 1'b0;
                            exploded <= 1'b1;
`endif
                        end else if (correct_cut) begin
                            progress <= progress + 3'd1;
                            if (progress == 3'd3) begin
                                st      <= DEFUSED;
                                start   <= 1'b0;
                                defused <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (arm_edge && wire_db == 4'b0000) begin
                            st       <= ARMED;
                            progress <= '0;
                            start    <= 1'b1;
                            defused  <= 1'b0;
                            exploded <= 1'b0;
`ifdef BOMB_STRIKE_EN
                            strike   <= 1'b0;
`endif
                        end
                    end
                endcase
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_bomb_defuse_ctrl.sv
// Directed bench for bomb_defuse_ctrl with DB_CYCLES=4; expected outputs are queued at stimulus time.
module tb_bomb_defuse_ctrl;

    localparam int DB  = 4;
    localparam int LAT = DB + 3;

    localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_DEF = 2'd2, S_EXP = 2'd3;

    logic       clk = 1'b0;
    logic       rst, power_sw, arm_btn, fail;
    logic [3:0] wire_cut;
    logic       start, bomb_switch, defused, exploded;
    logic [2:0] progress;
    logic [1:0] state;

    always #5 clk = ~clk;

    bomb_defuse_ctrl #(
        .DB_CYCLES(DB),
        .CODE     (8'b10_00_11_01)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .power_sw   (power_sw),
        .arm_btn    (arm_btn),
        .wire_cut   (wire_cut),
        .fail       (fail),
        .start      (start),
        .bomb_switch(bomb_switch),
        .defused    (defused),
        .exploded   (exploded),
        .progress   (progress),
        .state      (state)
    );

    typedef struct {
        string      tag;
        logic [8:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected vector: {state, start, bomb_switch, defused, exploded, progress}
    task automatic push(input string tag, input logic [1:0] st, input logic sta, input logic bs,
                        input logic d, input logic e, input logic [2:0] p);
        exp_t x;
        x.tag = tag;
        x.val = {st, sta, bs, d, e, p};
        sb.push_back(x);
    endtask

    task automatic check_pop();
        exp_t       x;
        logic [8:0] obs;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            x   = sb.pop_front();
            obs = {state, start, bomb_switch, defused, exploded, progress};
            checks++;
            assert (obs === x.val) else begin
                failures++;
                $error("FAIL %s observed=%b expected=%b", x.tag, obs, x.val);
            end
        end
    endtask

    task automatic settle(input string tag, input logic [1:0] st, input logic sta, input logic bs,
                          input logic d, input logic e, input logic [2:0] p);
        push(tag, st, sta, bs, d, e, p);
        tick(LAT);
        check_pop();
    endtask

    task automatic arm_and_release(input string tag);
        arm_btn = 1'b1;
        settle(tag, S_ARMED, 1, 1, 0, 0, 0);
        arm_btn = 1'b0;
        tick(LAT);
    endtask

    initial begin
        rst = 1'b0; power_sw = 1'b0; arm_btn = 1'b0; wire_cut = 4'b0000; fail = 1'b0;
        tick(3);
        push("reset", S_IDLE, 0, 0, 0, 0, 0);
        check_pop();
        rst = 1'b1;

        power_sw = 1'b1;
        settle("power_on", S_IDLE, 0, 1, 0, 0, 0);
        arm_and_release("arm");

        wire_cut = 4'b0010; settle("cut1", S_ARMED, 1, 1, 0, 0, 1);
        wire_cut = 4'b1010; settle("cut3", S_ARMED, 1, 1, 0, 0, 2);
        wire_cut = 4'b1011; settle("cut0", S_ARMED, 1, 1, 0, 0, 3);
        wire_cut = 4'b1111;
        push("last_cut_early", S_ARMED, 1, 1, 0, 0, 3);
        tick(LAT - 1);
        check_pop();
        push("defused", S_DEF, 0, 1, 1, 0, 4);
        tick(1);
        check_pop();

        wire_cut = 4'b0000; settle("restore_hold", S_DEF, 0, 1, 1, 0, 4);
        arm_and_release("rearm_defused");

`ifndef BOMB_STRIKE_EN
        wire_cut = 4'b0010; settle("wc_cut1", S_ARMED, 1, 1, 0, 0, 1);
        wire_cut = 4'b0011; settle("wrong_cut", S_EXP, 0, 1, 0, 1, 1);
`else
        wire_cut = 4'b0001; settle("strike_first", S_ARMED, 1, 1, 0, 0, 0);
        wire_cut = 4'b0011; settle("strike_cut1", S_ARMED, 1, 1, 0, 0, 1);
        wire_cut = 4'b1011; settle("strike_cut3", S_ARMED, 1, 1, 0, 0, 2);
        wire_cut = 4'b1111; settle("strike_second", S_EXP, 0, 1, 0, 1, 2);
`endif

        wire_cut = 4'b0000; tick(LAT);
        arm_and_release("rearm_exploded");

        fail = 1'b1;
        push("fuse_early", S_ARMED, 1, 1, 0, 0, 0);
        tick(1);
        fail = 1'b0;
        tick(1);
        check_pop();
        push("fuse_burnout", S_EXP, 0, 1, 0, 1, 0);
        tick(1);
        check_pop();

        arm_and_release("rearm_fuse");
        wire_cut = 4'b0010; settle("fv_cut1", S_ARMED, 1, 1, 0, 0, 1);
        wire_cut = 4'b1010; settle("fv_cut3", S_ARMED, 1, 1, 0, 0, 2);
        wire_cut = 4'b1011; settle("fv_cut0", S_ARMED, 1, 1, 0, 0, 3);
        wire_cut = 4'b1111;
        push("fail_vs_final_cut", S_EXP, 0, 1, 0, 1, 3);
        tick(4);
        fail = 1'b1;
        tick(1);
        fail = 1'b0;
        tick(2);
        check_pop();

        wire_cut = 4'b0000; tick(LAT);
        arm_and_release("rearm_glitch");
        wire_cut = 4'b0100;
        tick(3);
        wire_cut = 4'b0000;
        settle("glitch", S_ARMED, 1, 1, 0, 0, 0);
        wire_cut = 4'b0010; settle("pg_cut1", S_ARMED, 1, 1, 0, 0, 1);

        power_sw = 1'b0;
        settle("power_off", S_IDLE, 0, 0, 0, 0, 0);

        wire_cut = 4'b0001;
        power_sw = 1'b1;
        settle("power_on_wire_cut", S_IDLE, 0, 1, 0, 0, 0);
        arm_btn = 1'b1;
        settle("arm_blocked", S_IDLE, 0, 1, 0, 0, 0);
        arm_btn = 1'b0;
        tick(LAT);

        wire_cut = 4'b0000; tick(LAT);
        arm_and_release("rearm_reset");
        wire_cut = 4'b0010; settle("rs_cut1", S_ARMED, 1, 1, 0, 0, 1);
        wire_cut = 4'b1010;
        tick(3);
        #2 rst = 1'b0;
        #1;
        push("async_reset", S_IDLE, 0, 0, 0, 0, 0);
        check_pop();
        tick(2);
        rst = 1'b1;
        wire_cut = 4'b0000;
        arm_btn  = 1'b1;
        settle("post_reset_arm", S_ARMED, 1, 1, 0, 0, 0);
        arm_btn = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
